// File: rtl/conv55_line_feeder_if.sv
// Pixel-in / column-out bus of conv55_line_feeder; slave is the feeder, master drives pixels and watches columns.
// win_count and sof_err exist only when CONV55_FEEDER_STATS_EN is defined.
interface conv55_line_feeder_if #(
    parameter int BIT_WIDTH = 8,
    parameter int IMG_W     = 32,
    parameter int IMG_H     = 32
);
    logic signed [BIT_WIDTH-1:0] in_pix;
    logic                        in_valid;
    logic                        in_sof;
    logic                        in_ready;
    logic                        hold;
    logic [BIT_WIDTH*5-1:0]      out1;
    logic [BIT_WIDTH*5-1:0]      out2;
    logic [BIT_WIDTH*5-1:0]      out3;
    logic [BIT_WIDTH*5-1:0]      out4;
    logic [BIT_WIDTH*5-1:0]      out5;
    logic                        conv_en;
    logic                        win_valid;
    logic [$clog2(IMG_H)-1:0]    win_row;
    logic [$clog2(IMG_W)-1:0]    win_col;
    logic                        frame_done;
    logic                        busy;
`ifdef CONV55_FEEDER_STATS_EN
    logic [15:0]                 win_count;
    logic                        sof_err;
`endif

    modport slave (
        input  in_pix, in_valid, in_sof, hold,
`ifdef CONV55_FEEDER_STATS_EN
        output win_count, sof_err,
`endif
        output in_ready, out1, out2, out3, out4, out5,
        output conv_en, win_valid, win_row, win_col, frame_done, busy
    );

    modport master (
        output in_pix, in_valid, in_sof, hold,
`ifdef CONV55_FEEDER_STATS_EN
        input  win_count, sof_err,
`endif
        input  in_ready, out1, out2, out3, out4, out5,
        input  conv_en, win_valid, win_row, win_col, frame_done, busy
    );
endinterface

// File: rtl/conv55_line_feeder.sv
// Raster stream -> 5-row columns for conv55; column 1 cycle, window flag 2 cycles after accept; hold only drops in_ready.
// Optional CONV55_FEEDER_STATS_EN adds win_count (saturating) and sticky sof_err.
module conv55_line_feeder #(
    parameter int BIT_WIDTH = 8,
    parameter int IMG_W     = 32,
    parameter int IMG_H     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    conv55_line_feeder_if.slave  bus
);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam int OUT_W = BIT_WIDTH * 5;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [OUT_W-1:0] out1_q, out1_d, out2_q, out2_d, out3_q, out3_d;
    logic [OUT_W-1:0] out4_q, out4_d, out5_q, out5_d;
    logic             conv_en_q, conv_en_d;
    logic             tag_q, tag_d;
    logic [ROW_W-1:0] tag_row_q, tag_row_d;
    logic [COL_W-1:0] tag_col_q, tag_col_d;
    logic             win_valid_q, win_valid_d;
    logic [ROW_W-1:0] win_row_q, win_row_d;
    logic [COL_W-1:0] win_col_q, win_col_d;
    logic             frame_done_q, frame_done_d;

    logic [BIT_WIDTH-1:0] lb0_q [IMG_W];
    logic [BIT_WIDTH-1:0] lb1_q [IMG_W];
    logic [BIT_WIDTH-1:0] lb2_q [IMG_W];
    logic [BIT_WIDTH-1:0] lb3_q [IMG_W];

    logic             accept;
    logic             proc;
    logic             row_end;
    logic             last_pix;
    logic [ROW_W-1:0] pos_row;
    logic [COL_W-1:0] pos_col;

    function automatic logic [OUT_W-1:0] sext(input logic [BIT_WIDTH-1:0] p);
        return {{(OUT_W-BIT_WIDTH){p[BIT_WIDTH-1]}}, p};
    endfunction

    assign bus.in_ready = !bus.hold && (state_q != ST_DONE);
    assign accept       = bus.in_valid && bus.in_ready;
    // In IDLE only a start-of-frame pixel is taken; anything else is dropped.
    assign proc         = accept && (bus.in_sof || state_q == ST_FILL || state_q == ST_STREAM);
    assign pos_row      = bus.in_sof ? '0 : row_q;
    assign pos_col      = bus.in_sof ? '0 : col_q;
    assign row_end      = (pos_col == COL_LAST);
    assign last_pix     = row_end && (pos_row == ROW_LAST);

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        out1_d       = out1_q;
        out2_d       = out2_q;
        out3_d       = out3_q;
        out4_d       = out4_q;
        out5_d       = out5_q;
        conv_en_d    = proc;
        tag_d        = 1'b0;
        tag_row_d    = tag_row_q;
        tag_col_d    = tag_col_q;
        win_valid_d  = tag_q;
        win_row_d    = tag_q ? tag_row_q : win_row_q;
        win_col_d    = tag_q ? tag_col_q : win_col_q;
        frame_done_d = proc && last_pix;

        if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end else if (proc) begin
            out1_d = sext(lb3_q[pos_col]);
            out2_d = sext(lb2_q[pos_col]);
            out3_d = sext(lb1_q[pos_col]);
            out4_d = sext(lb0_q[pos_col]);
            out5_d = sext(bus.in_pix);
            if (pos_row >= ROW_W'(4) && pos_col >= COL_W'(4)) begin
                tag_d     = 1'b1;
                tag_row_d = pos_row - ROW_W'(4);
                tag_col_d = pos_col - COL_W'(4);
            end
            if (last_pix) begin
                state_d = ST_DONE;
                row_d   = '0;
                col_d   = '0;
            end else begin
                if (row_end) begin
                    col_d = '0;
                    row_d = pos_row + ROW_W'(1);
                end else begin
                    col_d = pos_col + COL_W'(1);
                    row_d = pos_row;
                end
                state_d = (row_d >= ROW_W'(4)) ? ST_STREAM : ST_FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            out1_q       <= '0;
            out2_q       <= '0;
            out3_q       <= '0;
            out4_q       <= '0;
            out5_q       <= '0;
            conv_en_q    <= 1'b0;
            tag_q        <= 1'b0;
            tag_row_q    <= '0;
            tag_col_q    <= '0;
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            out1_q       <= out1_d;
            out2_q       <= out2_d;
            out3_q       <= out3_d;
            out4_q       <= out4_d;
            out5_q       <= out5_d;
            conv_en_q    <= conv_en_d;
            tag_q        <= tag_d;
            tag_row_q    <= tag_row_d;
            tag_col_q    <= tag_col_d;
            win_valid_q  <= win_valid_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    // No reset on the line buffers: stale rows are masked by the window tag.
    always_ff @(posedge clk) begin
        if (proc) begin
            lb3_q[pos_col] <= lb2_q[pos_col];
            lb2_q[pos_col] <= lb1_q[pos_col];
            lb1_q[pos_col] <= lb0_q[pos_col];
            lb0_q[pos_col] <= bus.in_pix;
        end
    end

    assign bus.out1       = out1_q;
    assign bus.out2       = out2_q;
    assign bus.out3       = out3_q;
    assign bus.out4       = out4_q;
    assign bus.out5       = out5_q;
    assign bus.conv_en    = conv_en_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = (state_q == ST_FILL) || (state_q == ST_STREAM);

`ifdef CONV55_FEEDER_STATS_EN
    logic [15:0] win_count_q, win_count_d;
    logic        sof_err_q, sof_err_d;
    logic        sof_acc;

    assign sof_acc = accept && bus.in_sof;

    always_comb begin
        win_count_d = win_count_q;
        if (sof_acc) begin
            win_count_d = '0;
        end else if (win_valid_q && win_count_q != 16'hFFFF) begin
            win_count_d = win_count_q + 16'd1;
        end
        sof_err_d = sof_err_q || (sof_acc && (state_q == ST_FILL || state_q == ST_STREAM));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_count_q <= '0;
            sof_err_q   <= 1'b0;
        end else begin
            win_count_q <= win_count_d;
            sof_err_q   <= sof_err_d;
        end
    end

    assign bus.win_count = win_count_q;
    assign bus.sof_err   = sof_err_q;
`endif
endmodule

// File: tb/tb_conv55_line_feeder.sv
// Randomized and directed frames against a position/image model of the feeder, plus a tiny conv55 emulation.
module tb_conv55_line_feeder;
    localparam int BW = 8;
    localparam int W  = 32;
    localparam int H  = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    conv55_line_feeder_if #(.BIT_WIDTH(BW), .IMG_W(W), .IMG_H(H)) bus ();
    conv55_line_feeder #(.BIT_WIDTH(BW), .IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    // Model: the current frame image and where the next pixel lands.
    logic signed [7:0] img [H][W];
    bit          m_inframe, m_done;
    int          m_r, m_c, m_lr, m_lc;
    bit          e_cen, e_fd, e_busy, e_win, p_win;
    int          e_wrow, e_wcol, p_wrow, p_wcol;
    longint      e_wsum, p_wsum;
    logic [39:0] e_out [5];
    bit          e_def [5];

    // Emulated conv55 with an all-ones filter: last five latched column sums.
    longint      cs [5];
    int          win_seen, fd_seen, cen_seen;
    bit          first_got;
    longint      first_sum;
    int          first_r, first_c;
    bit          ramp_phase;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic logic [39:0] outv(input int k);
        case (k)
            0:       return bus.out1;
            1:       return bus.out2;
            2:       return bus.out3;
            3:       return bus.out4;
            default: return bus.out5;
        endcase
    endfunction

    task automatic model_init();
        m_inframe = 0; m_done = 0; m_r = 0; m_c = 0; m_lr = -1; m_lc = -1;
        e_cen = 0; e_fd = 0; e_busy = 0; e_win = 0; p_win = 0;
        e_wrow = 0; e_wcol = 0; p_wrow = 0; p_wcol = 0; e_wsum = 0; p_wsum = 0;
        for (int k = 0; k < 5; k++) begin
            e_out[k] = '0; e_def[k] = 1; cs[k] = 0;
        end
    endtask

    task automatic model_edge(input bit acc, input bit sof, input logic [7:0] p);
        bit prc;
        int r, c;
        logic signed [39:0] t;
        prc   = acc && (sof || m_inframe);
        e_cen = 0;
        e_fd  = 0;
        e_win = p_win; e_wrow = p_wrow; e_wcol = p_wcol; e_wsum = p_wsum;
        p_win = 0;
        m_done = 0;
        if (prc) begin
            if (sof) begin
                m_r = 0; m_c = 0;
            end
            r = m_r; c = m_c;
            m_lr = r; m_lc = c;
            img[r][c] = p;
            e_cen = 1;
            for (int k = 0; k < 5; k++) begin
                if (r - 4 + k >= 0) begin
                    t = img[r-4+k][c];
                    e_out[k] = t;
                    e_def[k] = 1;
                end else begin
                    e_def[k] = 0;
                end
            end
            if (r >= 4 && c >= 4) begin
                p_win = 1; p_wrow = r - 4; p_wcol = c - 4; p_wsum = 0;
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 5; j++)
                        p_wsum += longint'(img[r-4+i][c-4+j]);
            end
            if (r == H - 1 && c == W - 1) begin
                e_fd = 1; m_done = 1; m_inframe = 0; m_r = 0; m_c = 0;
            end else begin
                m_inframe = 1;
                m_c++;
                if (m_c == W) begin
                    m_c = 0; m_r++;
                end
            end
        end
        e_busy = m_inframe;
    endtask

    task automatic compare_outputs();
        longint s;
        chk("conv_en", bus.conv_en, e_cen);
        chk("win_valid", bus.win_valid, e_win);
        chk("frame_done", bus.frame_done, e_fd);
        chk("busy", bus.busy, e_busy);
        for (int k = 0; k < 5; k++)
            if (e_def[k]) chk($sformatf("out%0d", k + 1), outv(k), e_out[k]);
        if (bus.win_valid) begin
            s = cs[0] + cs[1] + cs[2] + cs[3] + cs[4];
            win_seen++;
            if (e_win) begin
                chk("win_row", bus.win_row, e_wrow);
                chk("win_col", bus.win_col, e_wcol);
                chk("win_sum", s, e_wsum);
            end
            if (!first_got) begin
                first_got = 1; first_sum = s; first_r = bus.win_row; first_c = bus.win_col;
            end
        end
        if (bus.frame_done) fd_seen++;
        if (bus.conv_en) begin
            cen_seen++;
            for (int k = 0; k < 4; k++) cs[k] = cs[k+1];
            cs[4] = longint'($signed(bus.out1)) + longint'($signed(bus.out2)) +
                    longint'($signed(bus.out3)) + longint'($signed(bus.out4)) +
                    longint'($signed(bus.out5));
        end
        if (ramp_phase && e_cen && m_lr == 5 && m_lc == 7) begin
            chk("col57_out1", bus.out1, 64'd39);
            chk("col57_out2", bus.out2, 64'd71);
            chk("col57_out3", bus.out3, 64'd103);
            chk("col57_out4", bus.out4, 64'd7);
            chk("col57_out5", bus.out5, 64'd39);
        end
    endtask

    // Called at a falling edge: drive, check in_ready, advance one clock, compare.
    task automatic step(input bit v, input bit s, input logic [7:0] p, input bit h, output bit acc);
        bus.in_valid = v; bus.in_sof = s; bus.in_pix = p; bus.hold = h;
        #1;
        chk("in_ready", bus.in_ready, !h && !m_done);
        acc = v && !h && !m_done;
        @(posedge clk);
        edge_n++;
        model_edge(acc, s, p);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, acc);
    endtask

    // pat 0 = ramp, 1 = random; hmode 0 = none, 1 = hold every other cycle, 2 = random hold/valid gaps
    task automatic run_pixels(input int k0, input int npix, input int pat, input int hmode, input bit sof0);
        int k, cyc, r, c;
        bit acc, v, h, s;
        logic [7:0] p;
        k = k0; cyc = 0;
        while (k < npix && cyc < 8000) begin
            r = k / W; c = k % W;
            p = (pat == 0) ? 8'((r * 32 + c) & 127) : 8'($urandom);
            s = sof0 && (k == k0);
            h = (hmode == 1) ? cyc[0] : (hmode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            v = (hmode == 2) ? ($urandom_range(0, 4) != 0) : 1'b1;
            step(v, s, p, h, acc);
            if (acc) k++;
            cyc++;
        end
        chk("stream_progress", k, npix);
    endtask

    task automatic phase_reset();
        win_seen = 0; fd_seen = 0; cen_seen = 0; first_got = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_conv_en"}, bus.conv_en, 0);
        chk({tag, "_win_valid"}, bus.win_valid, 0);
        chk({tag, "_win_row"}, bus.win_row, 0);
        chk({tag, "_win_col"}, bus.win_col, 0);
        chk({tag, "_frame_done"}, bus.frame_done, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_out1"}, bus.out1, 0);
        chk({tag, "_out5"}, bus.out5, 0);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        rst_n = 1'b0;
        bus.in_valid = 0; bus.in_sof = 0; bus.in_pix = '0; bus.hold = 0;
        ramp_phase = 0;
        model_init();
        phase_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Ramp frame, no stalls
        ramp_phase = 1;
        phase_reset();
        run_pixels(0, W * H, 0, 0, 1);
        ramp_phase = 0;
        cen_seen = 0;
        // First step lands in DONE, the rest are non-sof pixels in IDLE
        for (int i = 0; i < 6; i++) step(1, 0, 8'h11, 0, acc);
        chk("ramp_windows", win_seen, 784);
        chk("ramp_frame_done", fd_seen, 1);
        chk("ramp_first_row", first_r, 0);
        chk("ramp_first_col", first_c, 0);
        chk("ramp_first_sum", first_sum, 1010);
        chk("idle_no_conv_en", cen_seen, 0);
`ifdef CONV55_FEEDER_STATS_EN
        chk("win_count", bus.win_count, 784);
`endif

        // Start with a negative sof pixel, random data and stalls
        phase_reset();
        step(1, 1, 8'hFD, 0, acc);
        chk("sext_m3", bus.out5, 64'h00FF_FFFF_FFFD);
        chk("sof_start_busy", bus.busy, 1);
        run_pixels(1, W * H, 1, 2, 0);
        idle(4);
        chk("rand_windows", win_seen, 784);
        chk("rand_frame_done", fd_seen, 1);

        // hold toggling every other cycle
        phase_reset();
        run_pixels(0, W * H, 0, 1, 1);
        idle(4);
        chk("hold_windows", win_seen, 784);
        chk("hold_frame_done", fd_seen, 1);

        // sof at (10,3) restarts the frame
        phase_reset();
        run_pixels(0, 10 * W + 3, 1, 2, 1);
        run_pixels(0, W * H, 1, 0, 1);
        idle(4);
        chk("restart_windows", win_seen, 168 + 784);
        chk("restart_frame_done", fd_seen, 1);
`ifdef CONV55_FEEDER_STATS_EN
        chk("sof_err", bus.sof_err, 1);
`endif

        // Reset asserted at (20,15), then a full frame
        phase_reset();
        run_pixels(0, 20 * W + 15, 1, 0, 1);
        bus.in_valid = 0; bus.hold = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        model_init();
        @(negedge clk);
        rst_n = 1'b1;
        phase_reset();
        run_pixels(0, W * H, 1, 2, 1);
        idle(4);
        chk("post_reset_windows", win_seen, 784);
        chk("post_reset_frame_done", fd_seen, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/conv55_line_feeder.md
# conv55_line_feeder

Streaming line-buffer front end for `conv55`. It accepts a raster-order pixel stream one pixel per cycle and keeps the four previous image rows in on-chip line buffers. Each accepted pixel produces one 5-pixel column, which drives the `conv55` row inputs together with its latch enable. A registered window-valid flag marks the cycles in which the downstream `convValue` is a real 5x5 result. It sits between the feature-map BRAM reader and each `conv55` instance in the LeNet-5 pipeline.

## Interface
Parameters
- `BIT_WIDTH`, 8: pixel width in bits; signed.
- `IMG_W`, 32: image width in pixels; must be at least 5.
- `IMG_H`, 32: image height in pixels; must be at least 5.

Ports
- `clk`, input, 1: sole clock; all logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_pix`, input, BIT_WIDTH: signed input pixel.
- `in_valid`, input, 1: `in_pix` is valid this cycle.
- `in_sof`, input, 1: start of frame; qualified by `in_valid`.
- `in_ready`, output, 1: feeder can accept a pixel this cycle.
- `hold`, input, 1: downstream stall request.
- `out1`..`out5`, output, BIT_WIDTH*5 each: column pixels for rows r-4..r, sign-extended. These wire directly to `conv55` inputs `in1`..`in5`.
- `conv_en`, output, 1: one-cycle pulse that latches the column into `conv55`.
- `win_valid`, output, 1: the `conv55` output is a complete window this cycle.
- `win_row`, output, $clog2(IMG_H): output-map row of the current window.
- `win_col`, output, $clog2(IMG_W): output-map column of the current window.
- `frame_done`, output, 1: one-cycle pulse after the last pixel of a frame.
- `busy`, output, 1: high in the FILL and STREAM states.

## Operation
- A pixel is accepted when `in_valid && in_ready`.
- `in_ready` is `!hold` in IDLE, FILL and STREAM, and 0 in DONE.
- Counters `row` and `col` track the position of the accepted pixel.
- Line buffers: four arrays `lb0`..`lb3`, each IMG_W deep, where `lbk[c]` holds pixel (row-1-k, c).
- On an accepted pixel at column c, in the same edge:
  - `out5` is set to `in_pix`, `out4` to `lb0[c]`, `out3` to `lb1[c]`, `out2` to `lb2[c]`, `out1` to `lb3[c]`.
  - The arrays shift: `lb3[c]<=lb2[c]`, `lb2[c]<=lb1[c]`, `lb1[c]<=lb0[c]`, `lb0[c]<=in_pix`.
  - `conv_en` is set to 1.
- With no accepted pixel, `conv_en` is 0 and the `out*` registers hold their values.
- Line-buffer contents are undefined after reset. They are not cleared at a new frame, because `win_valid` masks every window that depends on them.
- FSM states:
  - IDLE: an accepted pixel with `in_sof=0` is discarded (no `conv_en`, no buffer write). An accepted pixel with `in_sof=1` is taken as (0,0), and the FSM goes to FILL.
  - FILL (row<4): pixels are processed normally and `win_valid` stays 0. The FSM enters STREAM when col wraps at the end of row 3.
  - STREAM: a window is tagged when the accepted pixel has col≥4. Its tag is `win_row = row-4` and `win_col = col-4`.
  - DONE: entered after the pixel at (IMG_H-1, IMG_W-1) is accepted. DONE lasts one cycle with `frame_done=1`, then returns to IDLE.
- col wraps from IMG_W-1 to 0 and increments row.
- `in_sof=1` on an accepted pixel in FILL or STREAM restarts the frame: that pixel becomes (0,0) and the state becomes FILL. A window tagged by the previous pixel still completes normally.
- `hold` only gates `in_ready`; it never drops a pixel or corrupts the `out*` registers.

## Timing
- Reset values: `out1`..`out5`=0, `conv_en`=0, `win_valid`=0, `win_row`=0, `win_col`=0, `frame_done`=0, `busy`=0, state=IDLE, row=col=0.
- `in_ready` in IDLE immediately after reset is `!hold`.
- A pixel accepted at edge N sets `out*`/`conv_en` after edge N, and `conv55` latches the column at edge N+1.
- `win_valid`, `win_row` and `win_col` are registered copies of the tag, delayed one extra cycle. They are therefore high in the cycle after edge N+1, the same cycle in which `convValue` is valid.
- Total latency from pixel acceptance to the corresponding `win_valid` is 2 cycles.
- `frame_done` rises one cycle after the last pixel is accepted. The last window's `win_valid` follows one cycle after that.
- Throughput is one pixel per cycle. A full frame yields exactly (IMG_H-4)*(IMG_W-4) `win_valid` pulses.
- Reset asserted mid-frame clears all state asynchronously. Any in-flight `win_valid` is lost.

## Configuration
- Macro `CONV55_FEEDER_STATS_EN`.
- When defined, two extra outputs are added:
  - `win_count` (16 bit): counts `win_valid` pulses. It clears on an sof-accepted pixel and saturates at 0xFFFF.
  - `sof_err` (1 bit): sticky flag set when `in_sof` arrives mid-frame in FILL or STREAM. It clears only on reset.
- When undefined, neither port exists and the behaviour is otherwise identical.

## Test plan
- Reset, then a 32x32 ramp frame with pixel = (row*32+col)&0x7F and no stalls:
  - Exactly 784 `win_valid` pulses.
  - The first pulse has `win_row=0`, `win_col=0`, and the `conv55` output with an all-ones filter equals the sum of the 5x5 block.
  - `frame_done` fires once.
- Column check: pixel accepted at (5,7) gives `out1..out5` = pixels (1,7),(2,7),(3,7),(4,7),(5,7), each sign-extended. Pixel value -3 (0xFD) appears as 0xFFFFFFFFFD.
- `hold` toggled every other cycle across a full frame → same 784 windows in the same order, no duplicates, and `conv_en` only on accepted pixels.
- Pixels with `in_sof=0` while in IDLE → `conv_en` stays 0. The next sof pixel starts the frame at (0,0).
- `in_sof` at (10,3) → frame restarts at (0,0), and no `win_valid` appears for the next 4 rows. With `CONV55_FEEDER_STATS_EN`, `sof_err=1`.
- `rst_n` dropped at (20,15) → all outputs return to reset values immediately. A following full frame produces 784 windows.
